weight_load_ctrl: RTL

WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

---
 rtl/weight_load_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/weight_load_ctrl.sv
// Double-buffered weight loader: streams load_len words into one of two RAM banks,
// tracks which banks hold a complete weight set, and ping-pongs between them.
module weight_load_ctrl #(
  parameter int DATA_WIDTH    = 64,
  parameter int WR_ADDR_DEPTH = 10
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [WR_ADDR_DEPTH:0]  load_len,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    wr_en,
  output logic                    wr_bank,
  output logic [WR_ADDR_DEPTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [1:0]              bank_full,
  input  logic [1:0]              bank_release,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BANK = 2'd1,
    LOAD      = 2'd2,
    DONE      = 2'd3
  } state_e;

  localparam logic [WR_ADDR_DEPTH:0] MAX_LEN = {1'b1, {WR_ADDR_DEPTH{1'b0}}};
  localparam logic [WR_ADDR_DEPTH:0] ONE     = {{WR_ADDR_DEPTH{1'b0}}, 1'b1};

  state_e                   state_q, state_d;
  logic [WR_ADDR_DEPTH:0]   len_q, len_d;
  logic [WR_ADDR_DEPTH:0]   cnt_q, cnt_d;
  logic                     tgt_q, tgt_d;
  logic [1:0]               full_q, full_d;
  logic                     s_ready_q, busy_q, done_q, err_q, err_d;
  logic                     wr_en_q, wr_en_d, wr_bank_q, wr_bank_d;
  logic [WR_ADDR_DEPTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                     accept;
  logic                     len_ok;

  assign accept = s_valid && s_ready_q;
  assign len_ok = (load_len != {(WR_ADDR_DEPTH+1){1'b0}}) && (load_len <= MAX_LEN);

  // Next-state, bank bookkeeping and write-port staging.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    err_d     = 1'b0;
    wr_en_d   = 1'b0;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    // Releases apply first so the DONE-cycle set below overrides a same-bank release.
    full_d    = full_q & ~bank_release;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!len_ok) begin
            err_d = 1'b1;
          end else begin
            len_d   = load_len;
            cnt_d   = {(WR_ADDR_DEPTH+1){1'b0}};
            state_d = full_q[tgt_q] ? WAIT_BANK : LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_BANK: begin
        if (!full_q[tgt_q]) begin
          state_d = LOAD;
        end else begin
          state_d = WAIT_BANK;
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_bank_d = tgt_q;
          wr_addr_d = cnt_q[WR_ADDR_DEPTH-1:0];
          wr_data_d = s_data;
          cnt_d     = cnt_q + ONE;
          if (cnt_q + ONE == len_q) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        full_d[tgt_q] = 1'b1;
        tgt_d         = ~tgt_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; status outputs decode the next state so they align with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      len_q     <= {(WR_ADDR_DEPTH+1){1'b0}};
      cnt_q     <= {(WR_ADDR_DEPTH+1){1'b0}};
      tgt_q     <= 1'b0;
      full_q    <= 2'b00;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= {WR_ADDR_DEPTH{1'b0}};
      wr_data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      full_q    <= full_d;
      s_ready_q <= (state_d == LOAD);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign bank_full = full_q;
  assign wr_en     = wr_en_q;
  assign wr_bank   = wr_bank_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule
